// File: rtl/dht_uart_responder.sv
// dht_uart_responder: command/response bridge between the UART RX/TX and the
// DHT11 reader. A known command triggers one acquisition, the five sensor
// bytes are checksum-validated, and a 2-byte reply (status, data) is streamed
// to the UART TX over a valid/ready handshake.
`timescale 1ns/1ps

module dht_uart_responder #(
  parameter int TIMEOUT_CYC = 5000000,
  parameter int CNT_W       = 23
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] CMD_DATA,
  input  logic       CMD_VALID,
  output logic       SENS_START,
  input  logic       SENS_DONE,
  input  logic       SENS_ERR,
  input  logic [7:0] HUM_INT,
  input  logic [7:0] HUM_FLOAT,
  input  logic [7:0] TEMP_INT,
  input  logic [7:0] TEMP_FLOAT,
  input  logic [7:0] CRC,
  output logic [7:0] TX_DATA,
  output logic       TX_VALID,
  input  logic       TX_READY,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    IDLE, TRIG, WAIT, CHECK, SEND_ST, SEND_DT
  } state_t;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_SENSERR = 8'h1F;
  localparam logic [7:0] ST_CRCERR  = 8'h2E;
  localparam logic [7:0] ST_TIMEOUT = 8'h2F;
  localparam logic [7:0] ST_UNKNOWN = 8'hFF;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       cmd_q, status_q, data_q;
  logic [7:0]       hi_q, hf_q, ti_q, tf_q, crc_q;
  logic             err_q;
  logic [9:0]       sum;
  logic [7:0]       sel_byte;

  function automatic logic is_known(input logic [7:0] c);
    return (c == 8'h01) || (c == 8'h02) || (c == 8'h03) || (c == 8'h04);
  endfunction

  // Checksum over the captured bytes; the carry out of bit 7 is dropped on purpose.
  assign sum = {2'b00, hi_q} + {2'b00, hf_q} + {2'b00, ti_q} + {2'b00, tf_q};

  // Reply data byte chosen by the latched command.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel_byte = 8'h00;
    case (cmd_q)
      8'h01:   sel_byte = ti_q;
      8'h02:   sel_byte = hi_q;
      8'h03:   sel_byte = tf_q;
      8'h04:   sel_byte = hf_q;
      default: sel_byte = 8'h00;
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (CMD_VALID) state_nx = is_known(CMD_DATA) ? TRIG : SEND_ST;
      TRIG:    state_nx = WAIT;
      WAIT:    if (SENS_DONE)           state_nx = CHECK;
               else if (cnt == CNT_LAST) state_nx = SEND_ST;
      CHECK:   state_nx = SEND_ST;
      SEND_ST: if (TX_READY) state_nx = SEND_DT;
      SEND_DT: if (TX_READY) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded purely from state, so an async reset drops them at once.
  always_comb begin
    SENS_START = 1'b0;
    TX_VALID   = 1'b0;
    TX_DATA    = 8'h00;
    BUSY       = (state != IDLE);
    case (state)
      TRIG:    SENS_START = 1'b1;
      SEND_ST: begin TX_VALID = 1'b1; TX_DATA = status_q; end
      SEND_DT: begin TX_VALID = 1'b1; TX_DATA = data_q;   end
      default: ;
    endcase
  end

  // Datapath: command latch, timeout counter, sensor capture and reply bytes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt      <= '0;
      cmd_q    <= 8'h00;
      status_q <= 8'h00;
      data_q   <= 8'h00;
      hi_q     <= 8'h00;
      hf_q     <= 8'h00;
      ti_q     <= 8'h00;
      tf_q     <= 8'h00;
      crc_q    <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (CMD_VALID) begin
          cmd_q <= CMD_DATA;
          if (!is_known(CMD_DATA)) begin
            status_q <= ST_UNKNOWN;
            data_q   <= CMD_DATA;
          end
        end
        TRIG: cnt <= '0;
        WAIT: begin
          if (SENS_DONE) begin
            hi_q  <= HUM_INT;
            hf_q  <= HUM_FLOAT;
            ti_q  <= TEMP_INT;
            tf_q  <= TEMP_FLOAT;
            crc_q <= CRC;
            err_q <= SENS_ERR;
          end else if (cnt == CNT_LAST) begin
            status_q <= ST_TIMEOUT;
            data_q   <= 8'h00;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          if (err_q) begin
            status_q <= ST_SENSERR;
            data_q   <= 8'h00;
          end else if (sum[7:0] != crc_q) begin
            status_q <= ST_CRCERR;
            data_q   <= 8'h00;
          end else begin
            status_q <= ST_OK;
            data_q   <= sel_byte;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dht_uart_responder.sv
// Testbench for dht_uart_responder: directed commands with a scoreboard of
// expected TX bytes, popped by a monitor on every TX handshake.
`timescale 1ns/1ps

module tb_dht_uart_responder;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] CMD_DATA = 8'h00;
  logic       CMD_VALID = 1'b0;
  logic       cmd_valid_b = 1'b0;
  logic       SENS_DONE = 1'b0;
  logic       SENS_ERR = 1'b0;
  logic [7:0] HUM_INT = 8'h00, HUM_FLOAT = 8'h00, TEMP_INT = 8'h00;
  logic [7:0] TEMP_FLOAT = 8'h00, CRC = 8'h00;
  logic       TX_READY = 1'b0;

  logic       SENS_START, TX_VALID, BUSY;
  logic [7:0] TX_DATA;
  logic       sens_start_b, tx_valid_b, busy_b;
  logic [7:0] tx_data_b;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b_q[$];

  always #5 CLK = ~CLK;

  // Main instance: default timeout, never reached by the directed tests.
  dht_uart_responder dut (
    .CLK(CLK), .RST(RST), .CMD_DATA(CMD_DATA), .CMD_VALID(CMD_VALID),
    .SENS_START(SENS_START), .SENS_DONE(SENS_DONE), .SENS_ERR(SENS_ERR),
    .HUM_INT(HUM_INT), .HUM_FLOAT(HUM_FLOAT), .TEMP_INT(TEMP_INT),
    .TEMP_FLOAT(TEMP_FLOAT), .CRC(CRC), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY), .BUSY(BUSY)
  );

  // Short-timeout instance, only commanded during the timeout test.
  dht_uart_responder #(.TIMEOUT_CYC(50), .CNT_W(23)) dut_b (
    .CLK(CLK), .RST(RST), .CMD_DATA(CMD_DATA), .CMD_VALID(cmd_valid_b),
    .SENS_START(sens_start_b), .SENS_DONE(SENS_DONE), .SENS_ERR(SENS_ERR),
    .HUM_INT(HUM_INT), .HUM_FLOAT(HUM_FLOAT), .TEMP_INT(TEMP_INT),
    .TEMP_FLOAT(TEMP_FLOAT), .CRC(CRC), .TX_DATA(tx_data_b), .TX_VALID(tx_valid_b),
    .TX_READY(1'b1), .BUSY(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: inputs change only just after posedge, so at negedge
  // valid&&ready is exactly what the next posedge will see.
  always @(negedge CLK) begin
    if (SENS_START) start_cnt++;
    if (TX_VALID && TX_READY) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_unexpected: got 0x%0h expected no byte", TX_DATA);
      end else begin
        check("tx_byte", {24'h0, TX_DATA}, {24'h0, exp_q.pop_front()});
      end
    end
    if (tx_valid_b) begin
      if (exp_b_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_b_unexpected: got 0x%0h expected no byte", tx_data_b);
      end else begin
        check("tx_b_byte", {24'h0, tx_data_b}, {24'h0, exp_b_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [7:0] c);
    CMD_DATA  = c;
    CMD_VALID = 1'b1;
    tick();
    CMD_VALID = 1'b0;
  endtask

  task automatic sens_done(input logic [7:0] hi, hf, ti, tf, crc, input logic err);
    HUM_INT = hi; HUM_FLOAT = hf; TEMP_INT = ti; TEMP_FLOAT = tf; CRC = crc;
    SENS_ERR  = err;
    SENS_DONE = 1'b1;
    tick();
    SENS_DONE = 1'b0;
    HUM_INT = 8'h00; HUM_FLOAT = 8'h00; TEMP_INT = 8'h00; TEMP_FLOAT = 8'h00;
    CRC = 8'h00; SENS_ERR = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (BUSY && k < budget) begin
      tick();
      k++;
    end
    check(name, {31'h0, BUSY}, 32'h0);
  endtask

  initial begin
    int s0;
    int n;
    logic stable;

    // Reset state.
    #2;
    check("rst_tx_valid", {31'h0, TX_VALID}, 0);
    check("rst_busy", {31'h0, BUSY}, 0);
    check("rst_tx_data", {24'h0, TX_DATA}, 0);
    check("rst_sens_start", {31'h0, SENS_START}, 0);
    tick(2);
    RST = 1'b0;
    tick();

    // Nominal TEMP_INT read: 0x37+0x00+0x19+0x00 = 0x50.
    TX_READY = 1'b1;
    s0 = start_cnt;
    exp_q.push_back(8'h00); exp_q.push_back(8'h19);
    send_cmd(8'h01);
    check("nom_start_latency", {31'h0, SENS_START}, 1);
    tick(99);
    sens_done(8'h37, 8'h00, 8'h19, 8'h00, 8'h50, 1'b0);
    check("nom_check_no_valid", {31'h0, TX_VALID}, 0);
    tick();
    check("nom_valid_latency", {31'h0, TX_VALID}, 1);
    wait_idle("nom_idle", 20);
    check("nom_one_start", start_cnt - s0, 1);
    check("nom_all_sent", exp_q.size(), 0);

    // HUM_INT with wrapping checksum: 0xFF+0x01 = 0x100 -> 0x00.
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    send_cmd(8'h02);
    tick(3);
    sens_done(8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
    wait_idle("wrap_idle", 20);
    check("wrap_all_sent", exp_q.size(), 0);

    // Same bytes, CRC off by one -> checksum mismatch.
    exp_q.push_back(8'h2E); exp_q.push_back(8'h00);
    send_cmd(8'h02);
    tick(3);
    sens_done(8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0);
    wait_idle("crc_idle", 20);
    check("crc_all_sent", exp_q.size(), 0);

    // TEMP_FLOAT with sensor error (checksum otherwise correct).
    exp_q.push_back(8'h1F); exp_q.push_back(8'h00);
    send_cmd(8'h03);
    tick(3);
    sens_done(8'h37, 8'h00, 8'h19, 8'h05, 8'h55, 1'b1);
    wait_idle("err_idle", 20);
    check("err_all_sent", exp_q.size(), 0);

    // Unknown command with TX_READY stalled for 10 cycles.
    TX_READY = 1'b0;
    s0 = start_cnt;
    exp_q.push_back(8'hFF); exp_q.push_back(8'h7A);
    send_cmd(8'h7A);
    check("unk_no_start", {31'h0, SENS_START}, 0);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(TX_VALID && TX_DATA == 8'hFF)) stable = 1'b0;
      tick();
    end
    check("unk_held_stable", {31'h0, stable}, 1);
    TX_READY = 1'b1;
    wait_idle("unk_idle", 20);
    check("unk_no_start_total", start_cnt - s0, 0);
    check("unk_all_sent", exp_q.size(), 0);

    // Second command during WAIT is dropped; HUM_FLOAT read, 0x28+5+0x16+3 = 0x46.
    s0 = start_cnt;
    exp_q.push_back(8'h00); exp_q.push_back(8'h05);
    send_cmd(8'h04);
    tick(5);
    send_cmd(8'h02);
    tick(5);
    sens_done(8'h28, 8'h05, 8'h16, 8'h03, 8'h46, 1'b0);
    wait_idle("busy_idle", 20);
    tick(10);
    check("busy_one_start", start_cnt - s0, 1);
    check("busy_single_reply", exp_q.size(), 0);

    // Async reset while the data byte is stalled in SEND_DT.
    TX_READY = 1'b0;
    exp_q.push_back(8'h00); exp_q.push_back(8'h19);
    send_cmd(8'h01);
    tick(2);
    sens_done(8'h37, 8'h00, 8'h19, 8'h00, 8'h50, 1'b0);
    tick();
    TX_READY = 1'b1;
    tick();
    TX_READY = 1'b0;
    check("rst_mid_dt_valid", {31'h0, TX_VALID}, 1);
    check("rst_mid_dt_data", {24'h0, TX_DATA}, 32'h19);
    #2;
    RST = 1'b1;
    #1;
    check("rst_async_valid", {31'h0, TX_VALID}, 0);
    check("rst_async_busy", {31'h0, BUSY}, 0);
    exp_q.delete();
    tick();
    RST = 1'b0;
    tick(2);
    check("rst_no_resume", {31'h0, TX_VALID}, 0);

    // Normal command after the reset.
    TX_READY = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'h37);
    send_cmd(8'h02);
    tick(4);
    sens_done(8'h37, 8'h00, 8'h19, 8'h00, 8'h50, 1'b0);
    wait_idle("post_rst_idle", 20);
    check("post_rst_all_sent", exp_q.size(), 0);

    // Timeout on the 50-cycle instance: 50 WAIT cycles, then the reply.
    exp_b_q.push_back(8'h2F); exp_b_q.push_back(8'h00);
    CMD_DATA    = 8'h01;
    cmd_valid_b = 1'b1;
    tick();
    cmd_valid_b = 1'b0;
    check("to_start", {31'h0, sens_start_b}, 1);
    tick();
    n = 0;
    while (!tx_valid_b && n < 200) begin
      n++;
      tick();
    end
    check("to_wait_cycles", n, 50);
    n = 0;
    while (busy_b && n < 20) begin
      n++;
      tick();
    end
    check("to_idle", {31'h0, busy_b}, 0);
    check("to_all_sent", exp_b_q.size(), 0);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
